// File: rtl/aes_pkg.sv
// Shared AES pipeline constants and helpers.
// Imported by the ciphertext output stage and its FIFO.
package aes_pkg;

  localparam int AES_BLOCK_LENGTH = 128;
  localparam int AES_PIPE_LATENCY = 11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/aes_ct_fifo.sv
// Ciphertext FIFO: unreset storage, wrapping pointers, occupancy.
// Head data is read combinationally at the read pointer.
module aes_ct_fifo
  import aes_pkg::*;
#(
  parameter int W     = AES_BLOCK_LENGTH,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] occ;

  always_ff @(posedge clk)
    if (wr) mem[wptr] <= wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      unique case ({wr, rd})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign empty = (occ == '0);
  assign head  = mem[rptr];

endmodule

// File: rtl/aes_ct_out_stage.sv
// AES-128 ciphertext output stage: valid pipe, credit flow control, FIFO.
// Define AES_CT_COUNT_EN to add the ct_count pop counter output.
module aes_ct_out_stage
  import aes_pkg::*;
#(
  parameter int BLOCK_LENGTH = AES_BLOCK_LENGTH,
  parameter int PIPE_LATENCY = AES_PIPE_LATENCY,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] ct_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] out_data,
  output logic                    drop_err
`ifdef AES_CT_COUNT_EN
  ,
  output logic [31:0]             ct_count
`endif
);

  localparam int CW = clog2(FIFO_DEPTH + 1);

  logic [PIPE_LATENCY-1:0] vpipe;
  logic [CW-1:0]           credits;
  logic                    accept;
  logic                    pop;
  logic                    ct_strobe;
  logic                    empty;

  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign ct_strobe = vpipe[PIPE_LATENCY-1];
  assign out_valid = !empty;
  // Registered credits only: no out_ready -> in_ready path
  assign in_ready  = (credits < CW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe <= '0;
    end else begin
      for (int i = PIPE_LATENCY - 1; i > 0; i--)
        vpipe[i] <= vpipe[i-1];
      vpipe[0] <= accept;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_err <= 1'b0;
    else if (in_valid && !in_ready)
      drop_err <= 1'b1;
  end

  aes_ct_fifo #(
    .W     (BLOCK_LENGTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (ct_strobe),
    .wdata (ct_in),
    .rd    (pop),
    .empty (empty),
    .head  (out_data)
  );

`ifdef AES_CT_COUNT_EN
  logic [31:0] ct_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ct_cnt <= '0;
    else if (pop)
      ct_cnt <= ct_cnt + 32'd1;
  end

  assign ct_count = ct_cnt;
`endif

endmodule

// File: tb/tb_aes_ct_out_stage.sv
// Directed bench for aes_ct_out_stage (depth-4 and depth-16 instances).
// Inputs change 1ns after posedge; outputs are sampled at that point.
module tb_aes_ct_out_stage;
  import aes_pkg::*;

  localparam int L  = 11;
  localparam int D  = 4;
  localparam int DW = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] ct_in = '0;

  logic         in_ready, out_valid, drop_err;
  logic [127:0] out_data;
  logic         w_in_ready, w_out_valid, w_drop_err;
  logic [127:0] w_out_data;
`ifdef AES_CT_COUNT_EN
  logic [31:0]  ct_count, w_ct_count;
`endif

  int total = 0;
  int bad   = 0;
  int acc;

  always #5 clk = ~clk;

  aes_ct_out_stage #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ct_in(ct_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .drop_err(drop_err)
`ifdef AES_CT_COUNT_EN
    , .ct_count(ct_count)
`endif
  );

  aes_ct_out_stage #(.FIFO_DEPTH(DW)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .ct_in(ct_in), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_data(w_out_data), .drop_err(w_drop_err)
`ifdef AES_CT_COUNT_EN
    , .ct_count(w_ct_count)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      assert (!(dut.ct_strobe && dut.u_fifo.occ == D)) else begin
        bad++;
        $error("FAIL fifo_overflow observed=%0d expected<%0d",
               dut.u_fifo.occ, D);
      end
    end
  end

  initial begin
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_drop_err", 128'(drop_err), 128'(0));
    tick();
    tick();
    rst = 1'b1;
    tick();

    // single block
    ct_in     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      chk("single_valid", 128'(out_valid), 128'(k == L + 1));
      if (k == L + 1)
        chk("single_data", out_data,
            128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      tick();
    end

    // back-to-back on the deep instance
    for (int k = 0; k <= 30; k++) begin
      chk("b2b_valid", 128'(w_out_valid),
          128'(k >= L + 1 && k <= L + 8));
      if (k >= L + 1 && k <= L + 8)
        chk("b2b_data", w_out_data, 128'(k - L));
      in_valid = (k < 8);
      ct_in    = (k >= L && k < L + 8) ? 128'(k - L + 1) : '0;
      tick();
    end
    in_valid = 1'b0;

    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // backpressure and drop on the depth-4 instance
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 4) chk("drop_before", 128'(drop_err), 128'(0));
      if (k == 5) chk("drop_set", 128'(drop_err), 128'(1));
      in_valid = 1'b1;
      ct_in    = (k >= L && k < L + 4) ? 128'(32'hA0 + k - L) : '0;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepts", 128'(acc), 128'(4));
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    chk("bp_out_valid", 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("pop_valid", 128'(out_valid), 128'(1));
      chk("pop_data", out_data, 128'(32'hA0 + j));
      if (j == 0) chk("pop_ready_lo", 128'(in_ready), 128'(0));
      if (j == 1) chk("pop_ready_hi", 128'(in_ready), 128'(1));
      tick();
    end
    for (int k = 0; k < 15; k++) begin
      chk("drop_no_extra", 128'(out_valid), 128'(0));
      tick();
    end
    chk("drop_sticky", 128'(drop_err), 128'(1));

    // reset mid-stream: 2 stored, 3 in flight on the deep instance
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    out_ready = 1'b0;
    ct_in     = 128'h55;
    for (int k = 0; k < 16; k++) begin
      in_valid = (k < 2) || (k >= 13 && k < 16);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_pre_valid", 128'(w_out_valid), 128'(1));
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(w_out_valid), 128'(0));
    chk("mid_rst_ready", 128'(w_in_ready), 128'(1));
    chk("mid_rst_drop", 128'(drop_err), 128'(0));
    chk("mid_rst_valid4", 128'(out_valid), 128'(0));
    #3;
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("mid_post_valid", 128'(w_out_valid), 128'(0));
    end
    chk("mid_post_ready", 128'(w_in_ready), 128'(1));

`ifdef AES_CT_COUNT_EN
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (5) tick();
    in_valid  = 1'b0;
    repeat (20) tick();
    chk("count_5", 128'(w_ct_count), 128'(5));
    force dut16.ct_cnt = 32'hFFFFFFFF;
    tick();
    release dut16.ct_cnt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    chk("count_wrap", 128'(w_ct_count), 128'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
